// File: rtl/cond_logic.sv
// Condition-check unit: holds the {N,Z,C,V} flag register and gates PC/regfile/memory write strobes.
// Flag updates land one cycle after the flag-setting instruction; CondEx and gated strobes are combinational.
module cond_logic (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  input  logic [1:0] FlagW,
  input  logic       PCS,
  input  logic       RegW,
  input  logic       MemW,
  input  logic       NoWrite,
  input  logic       Stall,
  output logic       PCSrc,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       CondEx,
  output logic [3:0] Flags
);

  logic [1:0] nz_q, nz_d;
  logic [1:0] cv_q, cv_d;
  logic       n_flag, z_flag, c_flag, v_flag;
  logic       cond_ex;

  assign n_flag = nz_q[1];
  assign z_flag = nz_q[0];
  assign c_flag = cv_q[1];
  assign v_flag = cv_q[0];

  // Evaluated against the stored flags only, so an instruction never sees its own result.
  always_comb begin
    cond_ex = 1'b0;
    unique case (Cond)
      4'b0000: cond_ex = z_flag;
      4'b0001: cond_ex = ~z_flag;
      4'b0010: cond_ex = c_flag;
      4'b0011: cond_ex = ~c_flag;
      4'b0100: cond_ex = n_flag;
      4'b0101: cond_ex = ~n_flag;
      4'b0110: cond_ex = v_flag;
      4'b0111: cond_ex = ~v_flag;
      4'b1000: cond_ex = c_flag & ~z_flag;
      4'b1001: cond_ex = ~c_flag | z_flag;
      4'b1010: cond_ex = (n_flag == v_flag);
      4'b1011: cond_ex = (n_flag != v_flag);
      4'b1100: cond_ex = ~z_flag & (n_flag == v_flag);
      4'b1101: cond_ex = z_flag | (n_flag != v_flag);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  always_comb begin
    nz_d = nz_q;
    cv_d = cv_q;
    if (cond_ex && !Stall) begin
      if (FlagW[1]) nz_d = ALUFlags[3:2];
      if (FlagW[0]) cv_d = ALUFlags[1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      nz_q <= 2'b00;
      cv_q <= 2'b00;
    end else begin
      nz_q <= nz_d;
      cv_q <= cv_d;
    end
  end

  assign CondEx   = cond_ex;
  assign PCSrc    = PCS & cond_ex;
  assign RegWrite = RegW & cond_ex & ~NoWrite;
  assign MemWrite = MemW & cond_ex;
  assign Flags    = {nz_q, cv_q};

endmodule

// File: tb/tb_cond_logic.sv
// Directed-vector bench for cond_logic with hand-computed expectations.
module tb_cond_logic;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] Cond;
  logic [3:0] ALUFlags;
  logic [1:0] FlagW;
  logic       PCS, RegW, MemW, NoWrite, Stall;
  logic       PCSrc, RegWrite, MemWrite, CondEx;
  logic [3:0] Flags;

  int n_tests = 0;
  int n_fail  = 0;

  cond_logic dut (
    .clk      (clk),
    .reset    (reset),
    .Cond     (Cond),
    .ALUFlags (ALUFlags),
    .FlagW    (FlagW),
    .PCS      (PCS),
    .RegW     (RegW),
    .MemW     (MemW),
    .NoWrite  (NoWrite),
    .Stall    (Stall),
    .PCSrc    (PCSrc),
    .RegWrite (RegWrite),
    .MemWrite (MemWrite),
    .CondEx   (CondEx),
    .Flags    (Flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; Cond = 4'h0; ALUFlags = 4'h0; FlagW = 2'b00;
    PCS = 1'b0; RegW = 1'b0; MemW = 1'b0; NoWrite = 1'b0; Stall = 1'b0;
    tick();
    reset = 1'b0;
    #1 chk("reset_flags", Flags, 4'b0000);

    Cond = 4'b0000; RegW = 1'b1;
    #1 chk("eq_after_reset_condex", {3'b0, CondEx}, 4'd0);
    chk("eq_after_reset_regwrite", {3'b0, RegWrite}, 4'd0);
    Cond = 4'b0001;
    #1 chk("ne_condex", {3'b0, CondEx}, 4'd1);
    chk("ne_regwrite", {3'b0, RegWrite}, 4'd1);
    Cond = 4'b1110;
    #1 chk("al_condex", {3'b0, CondEx}, 4'd1);
    RegW = 1'b0;

    // Full flag write, visible next cycle
    Cond = 4'b1110; FlagW = 2'b11; ALUFlags = 4'b0100;
    #1 chk("flags_not_yet_updated", Flags, 4'b0000);
    tick();
    FlagW = 2'b00; ALUFlags = 4'b0000;
    #1 chk("flags_z_loaded", Flags, 4'b0100);
    Cond = 4'b0000; MemW = 1'b1;
    #1 chk("eq_memwrite", {3'b0, MemWrite}, 4'd1);
    Cond = 4'b0001;
    #1 chk("ne_memwrite", {3'b0, MemWrite}, 4'd0);
    MemW = 1'b0;

    // Partial update: only C,V
    Cond = 4'b1110; FlagW = 2'b01; ALUFlags = 4'b1011;
    tick();
    FlagW = 2'b00;
    #1 chk("partial_cv", Flags, 4'b0111);
    Cond = 4'b1000;
    #1 chk("hi_condex", {3'b0, CondEx}, 4'd0);
    Cond = 4'b1001;
    #1 chk("ls_condex", {3'b0, CondEx}, 4'd1);

    // Failed condition blocks flag write; CondEx ignores ALUFlags
    reset = 1'b1;
    tick();
    reset = 1'b0;
    Cond = 4'b0000; FlagW = 2'b11; ALUFlags = 4'b1111;
    #1 chk("condex_uses_stored_flags", {3'b0, CondEx}, 4'd0);
    tick();
    #1 chk("failed_cond_no_flag_write", Flags, 4'b0000);
    Stall = 1'b1; Cond = 4'b1110; PCS = 1'b1;
    #1 chk("stall_not_gating_pcsrc", {3'b0, PCSrc}, 4'd1);
    tick();
    #1 chk("stall_holds_flags", Flags, 4'b0000);
    Stall = 1'b0; PCS = 1'b0;

    // Signed compare conditions with N=V=1
    Cond = 4'b1110; FlagW = 2'b11; ALUFlags = 4'b1001;
    tick();
    FlagW = 2'b00; ALUFlags = 4'b0000;
    #1 chk("flags_nv", Flags, 4'b1001);
    Cond = 4'b1010;
    #1 chk("ge_condex", {3'b0, CondEx}, 4'd1);
    Cond = 4'b1011;
    #1 chk("lt_condex", {3'b0, CondEx}, 4'd0);
    Cond = 4'b1100;
    #1 chk("gt_condex", {3'b0, CondEx}, 4'd1);
    Cond = 4'b1101;
    #1 chk("le_condex", {3'b0, CondEx}, 4'd0);
    Cond = 4'b1110; NoWrite = 1'b1; RegW = 1'b1;
    #1 chk("nowrite_regwrite", {3'b0, RegWrite}, 4'd0);
    chk("nowrite_condex", {3'b0, CondEx}, 4'd1);
    NoWrite = 1'b0;
    #1 chk("regwrite_restored", {3'b0, RegWrite}, 4'd1);
    RegW = 1'b0;

    // Reset wins over a simultaneous flag write
    reset = 1'b1; Cond = 4'b1110; FlagW = 2'b11; ALUFlags = 4'b1111;
    tick();
    reset = 1'b0; FlagW = 2'b00;
    #1 chk("reset_priority", Flags, 4'b0000);

    // Reserved condition: nothing commits
    Cond = 4'b1110; FlagW = 2'b11; ALUFlags = 4'b0110;
    tick();
    #1 chk("flags_preload", Flags, 4'b0110);
    Cond = 4'b1111; PCS = 1'b1; RegW = 1'b1; MemW = 1'b1; FlagW = 2'b11; ALUFlags = 4'b1001;
    #1 chk("rsv_gated", {CondEx, PCSrc, RegWrite, MemWrite}, 4'b0000);
    tick();
    #1 chk("rsv_flags_held", Flags, 4'b0110);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
